// File: rtl/three_phase_lut_sched.sv
// Three-phase sequencer for a shared half-wave sine ROM: folds each phase pointer
// into a ROM address plus sign and commits A/B/C samples together once per tick.
module three_phase_lut_sched #(
    parameter int DEPTH    = 10000,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 12,
    parameter int PRESCALE = 50,
    parameter int OFS_B    = 13333,
    parameter int OFS_C    = 6667
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    input  logic [7:0]        cfg_step,
    output logic              cfg_ready,
    input  logic              resync,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic              out_valid,
    output logic              busy
);
    localparam int PW = ADDR_W + 1;
    localparam int SW = ADDR_W + 2;
    localparam int CW = $clog2(PRESCALE);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [SW-1:0] WRAP_P  = SW'(2 * DEPTH);
    localparam logic [PW-1:0] OFSB_P  = PW'(OFS_B);
    localparam logic [PW-1:0] OFSC_P  = PW'(OFS_C);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        step_q, step_d;
    logic [PW-1:0]     pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [DATA_W-1:0] oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
    logic              ov_q, ov_d;
    logic              tick;
    logic [PW-1:0]     src_p;
    logic [DATA_W-1:0] sample;

    function automatic logic [ADDR_W-1:0] fold(input logic [PW-1:0] p);
        logic [PW-1:0] t;
        t = (p < DEPTH_P) ? p : p - DEPTH_P;
        return t[ADDR_W-1:0];
    endfunction

    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p, input logic [7:0] s);
        logic [SW-1:0] t;
        t = SW'(p) + SW'(s);
        if (t >= WRAP_P) t = t - WRAP_P;
        return t[PW-1:0];
    endfunction

    assign tick  = en && (cnt_q == CNT_MAX);
    assign cnt_d = tick || !en ? '0 : cnt_q + CW'(1);

    // Data arriving now belongs to the address presented last cycle, so the
    // sign comes from the previous phase's pointer (pointers are stable mid-sequence).
    always_comb begin
        case (state_q)
            RD_B:    src_p = pa_q;
            RD_C:    src_p = pb_q;
            default: src_p = pc_q;
        endcase
    end
    assign sample = (src_p >= DEPTH_P) ? -rom_data : rom_data;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        pc_d     = pc_q;
        pend_d   = pend_q | resync;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        oa_d     = oa_q;
        ob_d     = ob_q;
        oc_d     = oc_q;
        ov_d     = 1'b0;
        rom_addr = '0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) step_d = cfg_step;
                if (pend_q) begin
                    pa_d   = '0;
                    pb_d   = OFSB_P;
                    pc_d   = OFSC_P;
                    pend_d = resync;
                end
                if (tick) state_d = RD_A;
            end
            RD_A: begin
                rom_addr = fold(pa_q);
                state_d  = RD_B;
            end
            RD_B: begin
                rom_addr = fold(pb_q);
                sh_a_d   = sample;
                state_d  = RD_C;
            end
            RD_C: begin
                rom_addr = fold(pc_q);
                sh_b_d   = sample;
                state_d  = DONE;
            end
            DONE: begin
                oa_d    = sh_a_q;
                ob_d    = sh_b_q;
                oc_d    = sample;
                ov_d    = 1'b1;
                pa_d    = advance(pa_q, step_q);
                pb_d    = advance(pb_q, step_q);
                pc_d    = advance(pc_q, step_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 8'd1;
            pa_q    <= '0;
            pb_q    <= OFSB_P;
            pc_q    <= OFSC_P;
            pend_q  <= 1'b0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            oc_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            oc_q    <= oc_d;
            ov_q    <= ov_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_a     = oa_q;
    assign out_b     = ob_q;
    assign out_c     = oc_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_three_phase_lut_sched.sv
// Bench for three_phase_lut_sched: integer-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_three_phase_lut_sched;
    localparam int P = 5;

    logic        clk = 1'b0;
    logic        rst_n, en, cfg_valid, resync;
    logic [7:0]  cfg_step;
    logic        cfg_ready, out_valid, busy;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] out_a, out_b, out_c;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // model state
    int         m_cnt, m_ph, m_step;
    int         m_p [3];
    bit         m_pend, m_v;
    logic [11:0] m_o [3];

    three_phase_lut_sched #(.PRESCALE(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_step(cfg_step),
        .cfg_ready(cfg_ready), .resync(resync), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM content: addr mod 2048, one cycle read latency
    always @(posedge clk) rom_data <= {1'b0, rom_addr[10:0]};

    function automatic int fold(input int p);
        return (p < 10000) ? p : p - 10000;
    endfunction

    function automatic logic [11:0] samp(input int p);
        int m;
        m = fold(p) % 2048;
        return (p < 10000) ? 12'(m) : 12'(-m);
    endfunction

    task automatic model_step();
        bit tick;
        int ph0;
        if (!rst_n) begin
            m_cnt = 0; m_ph = 0; m_step = 1; m_pend = 0; m_v = 0;
            m_p[0] = 0; m_p[1] = 13333; m_p[2] = 6667;
            for (int i = 0; i < 3; i++) m_o[i] = '0;
        end else begin
            tick = en && (m_cnt == P - 1);
            ph0  = m_ph;
            m_v  = 0;
            if (ph0 == 4) begin
                for (int i = 0; i < 3; i++) m_o[i] = samp(m_p[i]);
                for (int i = 0; i < 3; i++) m_p[i] = (m_p[i] + m_step) % 20000;
                m_v  = 1;
                m_ph = 0;
            end else if (ph0 > 0) begin
                m_ph = ph0 + 1;
            end else begin
                if (cfg_valid) m_step = int'(cfg_step);
                if (m_pend) begin
                    m_p[0] = 0; m_p[1] = 13333; m_p[2] = 6667;
                end
                if (tick) m_ph = 1;
            end
            m_pend = resync || (m_pend && ph0 != 0);
            m_cnt  = (en && !tick) ? m_cnt + 1 : 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        int  ea;
        bit  bad;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                ea  = (m_ph >= 1 && m_ph <= 3) ? fold(m_p[m_ph-1]) : 0;
                bad = (out_valid !== m_v) || (out_a !== m_o[0]) || (out_b !== m_o[1]) ||
                      (out_c !== m_o[2]) || (busy !== (m_ph != 0)) || (cfg_ready !== (m_ph == 0)) ||
                      (m_ph != 4 && int'(rom_addr) != ea);
                n_vec++;
                if (bad) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: valid %b want %b, abc %0d %0d %0d want %0d %0d %0d, busy %b want %0d, addr %0d want %0d",
                             $time, out_valid, m_v, $signed(out_a), $signed(out_b), $signed(out_c),
                             $signed(m_o[0]), $signed(m_o[1]), $signed(m_o[2]), busy, m_ph != 0, rom_addr, ea);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("wait_busy_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 200);
        if (out_valid !== 1'b1) begin
            chk("wait_valid_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic rd_seq(input string tag);
        wait_busy();
        chk({tag, "_addrA"}, int'(rom_addr), 0);
        @(negedge clk);
        chk({tag, "_addrB"}, int'(rom_addr), 3333);
        @(negedge clk);
        chk({tag, "_addrC"}, int'(rom_addr), 6667);
    endtask

    task automatic chk_first(input string tag);
        chk({tag, "_a"}, int'($signed(out_a)), 0);
        chk({tag, "_b"}, int'($signed(out_b)), -1285);
        chk({tag, "_c"}, int'($signed(out_c)), 523);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a"}, int'(out_a), 0);
        chk({tag, "_b"}, int'(out_b), 0);
        chk({tag, "_c"}, int'(out_c), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(cfg_ready), 1);
        chk({tag, "_addr"}, int'(rom_addr), 0);
    endtask

    initial begin
        int n, c;
        rst_n = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_step = 8'd0; resync = 1'b0;

        // reset state and first sample
        @(negedge clk);
        chk_on = 1'b1;
        chk_reset("rst");
        rst_n = 1'b1;
        rd_seq("first");
        wait_valid(n);
        chk("first_lat", n, 2);
        chk_first("first");
        wait_valid(n);
        chk("period", n, P);

        // step 200: half-wave crossing after 50 samples, full wrap after 100
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cfg_valid = 1'b1; cfg_step = 8'd200;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("model_step200", m_step, 200);
        repeat (50) wait_valid(n);
        chk("model_pA_50", m_p[0], 10000);
        chk("model_pB_50", m_p[1], 3333);
        wait_valid(n);
        chk("s51_a", int'($signed(out_a)), 0);
        chk("s51_b", int'($signed(out_b)), 1285);
        chk("s51_c", int'($signed(out_c)), -523);
        repeat (49) wait_valid(n);
        wait_valid(n);
        chk_first("s101");

        // cfg held through a sequence: accepted only in IDLE, applied at next DONE
        wait_busy();
        chk("hold_addrA", int'(rom_addr), 200);
        cfg_valid = 1'b1; cfg_step = 8'd3;
        chk("hold_rdy_a", int'(cfg_ready), 0);
        @(negedge clk); chk("hold_rdy_b", int'(cfg_ready), 0);
        @(negedge clk); chk("hold_rdy_c", int'(cfg_ready), 0);
        @(negedge clk); chk("hold_rdy_d", int'(cfg_ready), 0);
        @(negedge clk); chk("hold_rdy_idle", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hold_next_addrA", int'(rom_addr), 400);
        wait_busy();
        chk("hold_step3_addrA", int'(rom_addr), 403);

        // en dropped during RD_B
        wait_busy();
        @(negedge clk);
        en = 1'b0;
        wait_valid(n);
        chk("endrop_lat", n, 3);
        c = 0;
        repeat (20) begin @(negedge clk); if (out_valid) c++; end
        chk("endrop_quiet", c, 0);
        en = 1'b1;
        wait_valid(n);
        chk("enrise_lat", n, P + 4);

        // resync during RD_C
        wait_busy();
        @(negedge clk);
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        rd_seq("resync");

        // step 0: outputs freeze, out_valid keeps pulsing
        wait_valid(n);
        cfg_valid = 1'b1; cfg_step = 8'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("model_step0", m_step, 0);
        wait_valid(n);
        wait_valid(n);
        chk("step0_period", n, P);

        // reset during RD_B
        wait_busy();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        rst_n = 1'b1;
        rd_seq("postrst");
        wait_valid(n);
        chk_first("postrst");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
